ssd_scan_ctrl: RTL and testbench

- Parametrised, time-multiplexed seven-segment driver.
- Drives DIGITS common-anode digits from one shared active-low segment bus by scanning the digit selects at a programmable refresh rate.
- Adds a load-strobed shadow register (no tearing), per-digit decimal points, leading-zero blanking and a global display enable.
- Sits between user datapath logic and the board's SSD pins.

---
 rtl/ssd_scan_ctrl.sv | 117 +++++++++++
 tb/tb_ssd_scan_ctrl.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/ssd_scan_ctrl.sv
// ssd_scan_ctrl: time-multiplexed common-anode seven-segment scan driver.
// Define SSD_HEX_EN to decode nibbles 10-15 as A,b,C,d,E,F glyphs.
module ssd_scan_ctrl #(
  parameter int DIGITS      = 4,
  parameter int REFRESH_DIV = 100000,
  parameter int CNT_W       = $clog2(REFRESH_DIV)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [4*DIGITS-1:0] value,
  input  logic [DIGITS-1:0]   dp,
  input  logic                load,
  input  logic                lz_blank,
  input  logic                disp_en,
  output logic [7:0]          segs,
  output logic [DIGITS-1:0]   digit_sel
);

  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic [CNT_W-1:0]    cnt;
  logic [IDX_W-1:0]    idx;
  logic [4*DIGITS-1:0] shadow_val;
  logic [DIGITS-1:0]   shadow_dp;
  logic                wrap;
  logic [3:0]          nib;
  logic [DIGITS-1:0]   blank_mask;
  logic                upper_zero;
  logic                blank;
  logic [6:0]          glyph;

  assign wrap = (cnt == CNT_W'(REFRESH_DIV - 1));

  // active-low a..g glyph for one nibble
  function automatic logic [6:0] decode(input logic [3:0] n);
    logic [6:0] g;
    case (n)
      4'd0:    g = 7'b0000001;
      4'd1:    g = 7'b1001111;
      4'd2:    g = 7'b0010010;
      4'd3:    g = 7'b0000110;
      4'd4:    g = 7'b1001100;
      4'd5:    g = 7'b0100100;
      4'd6:    g = 7'b0100000;
      4'd7:    g = 7'b0001111;
      4'd8:    g = 7'b0000000;
      4'd9:    g = 7'b0000100;
`ifdef SSD_HEX_EN
      4'd10:   g = 7'b0001000;
      4'd11:   g = 7'b1100000;
      4'd12:   g = 7'b0110001;
      4'd13:   g = 7'b1000010;
      4'd14:   g = 7'b0110000;
      default: g = 7'b0111000;
`else
      default: g = 7'b0111000;
`endif
    endcase
    return g;
  endfunction

  // dwell counter; index steps to the next digit on wrap
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
      idx <= '0;
    end else if (wrap) begin
      cnt <= '0;
      if (idx == IDX_W'(DIGITS - 1))
        idx <= '0;
      else
        idx <= idx + IDX_W'(1);
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // shadow copy so a half-updated value never shows
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shadow_val <= '0;
      shadow_dp  <= '0;
    end else if (load) begin
      shadow_val <= value;
      shadow_dp  <= dp;
    end
  end

  // digit k blanks when it and every digit left of it are zero
  always_comb begin
    upper_zero = 1'b1;
    blank_mask = '0;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      upper_zero    = upper_zero && (shadow_val[4*k +: 4] == 4'd0);
      blank_mask[k] = upper_zero && (k != 0);
    end
  end

  assign nib   = shadow_val[{idx, 2'b00} +: 4];
  assign blank = lz_blank & blank_mask[idx];
  assign glyph = blank ? 7'h7F : decode(nib);

  // registered pin drivers for the digit at the current index
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      segs      <= 8'hFF;
      digit_sel <= '1;
    end else if (disp_en) begin
      segs      <= {glyph, ~shadow_dp[idx]};
      digit_sel <= ~(DIGITS'(1) << idx);
    end else begin
      segs      <= 8'hFF;
      digit_sel <= '1;
    end
  end

endmodule

// File: tb/tb_ssd_scan_ctrl.sv
// tb_ssd_scan_ctrl: directed and random checks of the scan driver
// against a cycle-count based reference model.
module tb_ssd_scan_ctrl;

  localparam int D  = 4;
  localparam int RD = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [15:0]   value;
  logic [3:0]    dp;
  logic          load;
  logic          lz_blank;
  logic          disp_en;
  logic [7:0]    segs;
  logic [3:0]    digit_sel;

  int n_checks = 0;
  int n_fail   = 0;

  // model state
  int          m_tick = 0;
  logic [15:0] m_val  = '0;
  logic [3:0]  m_dp   = '0;
  logic [7:0]  e_segs;
  logic [3:0]  e_sel;

  ssd_scan_ctrl #(.DIGITS(D), .REFRESH_DIV(RD)) dut (
    .clk(clk), .rst_n(rst_n), .value(value), .dp(dp),
    .load(load), .lz_blank(lz_blank), .disp_en(disp_en),
    .segs(segs), .digit_sel(digit_sel)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] glyph_of(input logic [3:0] n);
    logic [6:0] t [16];
    t[0] = 7'b0000001; t[1] = 7'b1001111;
    t[2] = 7'b0010010; t[3] = 7'b0000110;
    t[4] = 7'b1001100; t[5] = 7'b0100100;
    t[6] = 7'b0100000; t[7] = 7'b0001111;
    t[8] = 7'b0000000; t[9] = 7'b0000100;
`ifdef SSD_HEX_EN
    t[10] = 7'b0001000; t[11] = 7'b1100000;
    t[12] = 7'b0110001; t[13] = 7'b1000010;
    t[14] = 7'b0110000; t[15] = 7'b0111000;
`else
    for (int i = 10; i < 16; i++) t[i] = 7'b0111000;
`endif
    return t[n];
  endfunction

  task automatic check8(input string nm, input logic [7:0] got,
                        input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
    end
  endtask

  // reference: digit k is active during cycles [k*RD, (k+1)*RD) mod D*RD
  always @(posedge clk) begin
    if (!rst_n) begin
      e_segs = 8'hFF;
      e_sel  = 4'hF;
      m_tick = 0;
      m_val  = '0;
      m_dp   = '0;
    end else begin
      int k, msd;
      logic [6:0] g;
      k   = (m_tick / RD) % D;
      msd = 0;
      for (int i = 0; i < D; i++)
        if (m_val[4*i +: 4] != 0) msd = i;
      g = (lz_blank && k > msd) ? 7'h7F : glyph_of(m_val[4*k +: 4]);
      if (disp_en) begin
        e_segs = {g, ~m_dp[k]};
        e_sel  = ~(4'b0001 << k);
      end else begin
        e_segs = 8'hFF;
        e_sel  = 4'hF;
      end
      if (load) begin
        m_val = value;
        m_dp  = dp;
      end
      m_tick++;
    end
    #1;
    check8("model_segs", segs, e_segs);
    check8("model_sel", {4'h0, digit_sel}, {4'h0, e_sel});
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_sel(input logic [3:0] s);
    int b;
    b = 0;
    while (digit_sel !== s && b < 40) begin
      @(negedge clk);
      b++;
    end
    n_checks++;
    if (digit_sel !== s) begin
      n_fail++;
      $display("FAIL wait_sel: got %b expected %b (timeout)", digit_sel, s);
    end
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] d);
    value = v;
    dp    = d;
    load  = 1'b1;
    step(1);
    load  = 1'b0;
    step(2);
  endtask

  // four digits in scan order starting at digit 0
  task automatic check_scan(input string nm, input logic [7:0] s0,
                            input logic [7:0] s1, input logic [7:0] s2,
                            input logic [7:0] s3);
    wait_sel(4'b1110);
    check8({nm, "_d0"}, segs, s0);
    step(RD);
    check8({nm, "_sel1"}, {4'h0, digit_sel}, 8'h0D);
    check8({nm, "_d1"}, segs, s1);
    step(RD);
    check8({nm, "_sel2"}, {4'h0, digit_sel}, 8'h0B);
    check8({nm, "_d2"}, segs, s2);
    step(RD);
    check8({nm, "_sel3"}, {4'h0, digit_sel}, 8'h07);
    check8({nm, "_d3"}, segs, s3);
    step(RD);
    check8({nm, "_wrap"}, {4'h0, digit_sel}, 8'h0E);
  endtask

  initial begin
    rst_n    = 1'b0;
    value    = 16'h1234;
    dp       = 4'h0;
    load     = 1'b1;
    lz_blank = 1'b0;
    disp_en  = 1'b1;
    step(3);
    check8("rst_segs", segs, 8'hFF);
    check8("rst_sel", {4'h0, digit_sel}, 8'h0F);
    load  = 1'b0;
    rst_n = 1'b1;
    step(1);
    check8("first_sel", {4'h0, digit_sel}, 8'h0E);
    check8("first_segs", segs, 8'h03);

    do_load(16'h1234, 4'b0100);
    check_scan("scan", 8'h99, 8'h0D, 8'h24, 8'h9F);

    lz_blank = 1'b1;
    do_load(16'h0050, 4'b0000);
    check_scan("blank", 8'h03, 8'h49, 8'hFF, 8'hFF);
    do_load(16'h0000, 4'b0000);
    check_scan("zero", 8'h03, 8'hFF, 8'hFF, 8'hFF);

    lz_blank = 1'b0;
    value    = 16'h9999;
    step(20);
    wait_sel(4'b1110);
    check8("shadow_hold", segs, 8'h03);
    load = 1'b1;
    step(1);
    load = 1'b0;
    step(1);
    check8("load_vis", segs, 8'h09);
    check8("load_sel", {4'h0, digit_sel}, 8'h0E);

    step(1);
    disp_en = 1'b0;
    step(1);
    check8("off_segs", segs, 8'hFF);
    check8("off_sel", {4'h0, digit_sel}, 8'h0F);
    step(5);
    disp_en = 1'b1;
    step(4);

`ifdef SSD_HEX_EN
    do_load(16'hABCF, 4'b0000);
    check_scan("hex", 8'h71, 8'h63, 8'hC1, 8'h11);
`else
    do_load(16'hABCF, 4'b0000);
    check_scan("hex", 8'h71, 8'h71, 8'h71, 8'h71);
`endif

    for (int i = 0; i < 400; i++) begin
      value    = 16'($urandom);
      if ($urandom_range(0, 2) == 0) value[15:8] = 8'h00;
      dp       = 4'($urandom);
      load     = ($urandom_range(0, 4) == 0);
      lz_blank = 1'($urandom);
      disp_en  = ($urandom_range(0, 7) != 0);
      rst_n    = ($urandom_range(0, 99) != 0);
      step(1);
    end
    rst_n = 1'b1;
    load  = 1'b0;
    step(2);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
